ser_feed: RTL and testbench

SER_FEED -- requirements
Module: ser_feed

---
 rtl/ser_feed.sv | 190 +++++++++++++++++++
 tb/tb_ser_feed.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_feed.sv
// ser_feed: parallel-to-serial feeder for a downstream serial sequence detector.
// A word is accepted on a din_valid/din_ready handshake and shifted out one bit
// per cycle on x, optionally followed by a fixed number of idle gap cycles.
// With GAP=0 a new word can be accepted while the previous word's final bit is
// on x, giving a gapless bit stream.

module ser_feed #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int                 CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(WIDTH - 1);
  localparam logic [3:0]         GAP_TOP = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit                 NO_GAP  = (GAP == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [3:0]       gap_cnt_r;
  logic             x_r;
  logic             x_valid_r;
  logic             last_r;
  logic             busy_r;

  logic             final_bit_s;
  logic             din_ready_s;
  logic             accept_s;

  // First bit of a freshly loaded word, honouring the transmit order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  // Bit that follows the one currently on x; the shift register keeps the
  // on-wire bit at its outgoing end, so the next bit sits one position in.
  function automatic logic next_bit(input logic [WIDTH-1:0] s);
    if (MSB_FIRST) begin
      return s[WIDTH-2];
    end else begin
      return s[1];
    end
  endfunction

  // Advance the shift register by one bit toward its outgoing end.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] s);
    if (MSB_FIRST) begin
      return {s[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, s[WIDTH-1:1]};
    end
  endfunction

  // Handshake: ready in IDLE, or on the final bit when no gap is configured.
  always_comb begin
    final_bit_s = (state_r == ST_SHIFT) && (bit_cnt_r == '0);
    din_ready_s = 1'b0;
    if (!rst) begin
      din_ready_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      din_ready_s = 1'b1;
    end else if (final_bit_s && NO_GAP) begin
      din_ready_s = 1'b1;
    end else begin
      din_ready_s = 1'b0;
    end
    accept_s = din_ready_s & din_valid;
  end

  assign din_ready = din_ready_s;

  // Serializer state machine with registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      gap_cnt_r <= 4'd0;
      x_r       <= 1'b0;
      x_valid_r <= 1'b0;
      last_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_SHIFT;
            shift_r   <= din;
            bit_cnt_r <= CNT_TOP;
            x_r       <= first_bit(din);
            x_valid_r <= 1'b1;
            last_r    <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            x_r       <= 1'b0;
            x_valid_r <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (bit_cnt_r != '0) begin
            // Mid-word: present the next bit, flag it when it is the final one.
            x_r       <= next_bit(shift_r);
            shift_r   <= shift_step(shift_r);
            bit_cnt_r <= bit_cnt_r - CNT_W'(1);
            last_r    <= (bit_cnt_r == CNT_W'(1));
            x_valid_r <= 1'b1;
            busy_r    <= 1'b1;
          end else if (accept_s) begin
            // Gapless back-to-back: the next word starts right after the final bit.
            shift_r   <= din;
            bit_cnt_r <= CNT_TOP;
            x_r       <= first_bit(din);
            x_valid_r <= 1'b1;
            last_r    <= 1'b0;
            busy_r    <= 1'b1;
          end else if (NO_GAP) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            x_r       <= 1'b0;
            x_valid_r <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
          end else begin
            state_r   <= ST_GAP;
            shift_r   <= '0;
            gap_cnt_r <= GAP_TOP;
            x_r       <= 1'b0;
            x_valid_r <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b1;
          end
        end

        ST_GAP: begin
          x_r       <= 1'b0;
          x_valid_r <= 1'b0;
          last_r    <= 1'b0;
          if (gap_cnt_r == 4'd0) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
            busy_r    <= 1'b1;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          shift_r   <= '0;
          bit_cnt_r <= '0;
          gap_cnt_r <= 4'd0;
          x_r       <= 1'b0;
          x_valid_r <= 1'b0;
          last_r    <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign x       = x_r;
  assign x_valid = x_valid_r;
  assign last    = last_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_ser_feed.sv
// Testbench for ser_feed: two instances share one stimulus stream.
//   dut_a: WIDTH=8, MSB_FIRST=1, GAP=0
//   dut_b: WIDTH=8, MSB_FIRST=0, GAP=2
// A schedule-based reference model (one queue of expected output cycles per
// instance) checks every cycle; table vectors and hand sequences add explicit
// expectations for the reset, single-word, streaming, gap and hold cases.

module tb_ser_feed;

  localparam bit MSB_A = 1'b1;
  localparam int GAP_A = 0;
  localparam bit MSB_B = 1'b0;
  localparam int GAP_B = 2;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready_a, x_a, xv_a, last_a, busy_a;
  logic       din_ready_b, x_b, xv_b, last_b, busy_b;

  ser_feed #(.WIDTH(8), .MSB_FIRST(MSB_A), .GAP(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_a), .x(x_a), .x_valid(xv_a), .last(last_a), .busy(busy_a)
  );

  ser_feed #(.WIDTH(8), .MSB_FIRST(MSB_B), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_b), .x(x_b), .x_valid(xv_b), .last(last_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic x;
    logic xv;
    logic last;
    logic busy;
  } exp_t;

  typedef struct {
    logic       r;
    logic       dv;
    logic [7:0] d;
    logic       rdy;
    logic       x;
    logic       xv;
    logic       last;
    logic       busy;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  vec_t vt[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        s_rdy_a, s_rdy_b;
  logic        s_x_a, s_xv_a, s_last_a, s_busy_a;
  logic        s_x_b, s_xv_b, s_last_b, s_busy_b;
  logic [15:0] col_a, col_b;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic put(input int which, input exp_t e);
    if (which == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Expected output cycles for one accepted word: WIDTH bits, GAP idle-busy
  // cycles, and with a gap one further idle cycle before the next accept.
  task automatic sched(input int which, input logic [7:0] w);
    exp_t e;
    bit   msb;
    int   gap;
    msb = (which == 0) ? MSB_A : MSB_B;
    gap = (which == 0) ? GAP_A : GAP_B;
    for (int i = 0; i < 8; i++) begin
      e.x    = msb ? w[7-i] : w[i];
      e.xv   = 1'b1;
      e.last = (i == 7);
      e.busy = 1'b1;
      put(which, e);
    end
    for (int g = 0; g < gap; g++) begin
      e      = '0;
      e.busy = 1'b1;
      put(which, e);
    end
    if (gap > 0) begin
      e = '0;
      put(which, e);
    end
  endtask

  // One clock cycle: drive inputs, check ready before the edge, advance the
  // model at the edge, check registered outputs just after it.
  task automatic do_cycle(input logic r, input logic dv, input logic [7:0] d);
    logic er_a, er_b;
    exp_t ea, eb;
    rst       = r;
    din_valid = dv;
    din       = d;
    @(negedge clk);
    er_a    = r && (qa.size() == 0);
    er_b    = r && (qb.size() == 0);
    s_rdy_a = din_ready_a;
    s_rdy_b = din_ready_b;
    chk("ready_a", 16'(din_ready_a), 16'(er_a));
    chk("ready_b", 16'(din_ready_b), 16'(er_b));
    @(posedge clk);
    if (!r) begin
      qa.delete();
      qb.delete();
    end else begin
      if (dv && er_a) sched(0, d);
      if (dv && er_b) sched(1, d);
    end
    ea = '0;
    eb = '0;
    if (qa.size() > 0) ea = qa.pop_front();
    if (qb.size() > 0) eb = qb.pop_front();
    #1;
    s_x_a = x_a; s_xv_a = xv_a; s_last_a = last_a; s_busy_a = busy_a;
    s_x_b = x_b; s_xv_b = xv_b; s_last_b = last_b; s_busy_b = busy_b;
    chk("x_a",    16'(x_a),    16'(ea.x));
    chk("xv_a",   16'(xv_a),   16'(ea.xv));
    chk("last_a", 16'(last_a), 16'(ea.last));
    chk("busy_a", 16'(busy_a), 16'(ea.busy));
    chk("x_b",    16'(x_b),    16'(eb.x));
    chk("xv_b",   16'(xv_b),   16'(eb.xv));
    chk("last_b", 16'(last_b), 16'(eb.last));
    chk("busy_b", 16'(busy_b), 16'(eb.busy));
    if (xv_a) col_a = {col_a[14:0], x_a};
    if (xv_b) col_b = {col_b[14:0], x_b};
  endtask

  task automatic addv(input logic r, input logic dv, input logic [7:0] d, input logic rdy,
                      input logic x, input logic xv, input logic last, input logic busy);
    vec_t v;
    v.r = r; v.dv = dv; v.d = d; v.rdy = rdy;
    v.x = x; v.xv = xv; v.last = last; v.busy = busy;
    vt.push_back(v);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] w1;
    logic [7:0] w2;
    logic [7:0] w3;

    col_a = 16'h0000;
    col_b = 16'h0000;

    // Vector table for dut_a: reset, single word A5, back-to-back 0A/AA.
    w1 = 8'hA5;
    w2 = 8'h0A;
    w3 = 8'hAA;
    addv(1'b0, 1'b1, w1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 1'b1, w1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b1, 1'b1, w1, 1'b1, w1[7], 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) addv(1'b1, 1'b0, w1, 1'b0, w1[7-i], 1'b1, (i == 7), 1'b1);
    addv(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b1, 1'b1, w2, 1'b1, w2[7], 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) addv(1'b1, 1'b1, w3, 1'b0, w2[7-i], 1'b1, (i == 7), 1'b1);
    addv(1'b1, 1'b1, w3, 1'b1, w3[7], 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) addv(1'b1, 1'b0, 8'h00, 1'b0, w3[7-i], 1'b1, (i == 7), 1'b1);
    addv(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      do_cycle(vt[i].r, vt[i].dv, vt[i].d);
      chk($sformatf("tbl%0d_rdy", i),  16'(s_rdy_a),  16'(vt[i].rdy));
      chk($sformatf("tbl%0d_x", i),    16'(s_x_a),    16'(vt[i].x));
      chk($sformatf("tbl%0d_xv", i),   16'(s_xv_a),   16'(vt[i].xv));
      chk($sformatf("tbl%0d_last", i), 16'(s_last_a), 16'(vt[i].last));
      chk($sformatf("tbl%0d_busy", i), 16'(s_busy_a), 16'(vt[i].busy));
    end
    chk("stream_0A_AA", col_a, 16'b0000101010101010);

    // Gap behaviour on dut_b: 01 LSB-first, two gap cycles, then 80 accepted.
    idle_cycles(12);
    do_cycle(1'b1, 1'b1, 8'h01);
    chk("gap_first_rdy", 16'(s_rdy_b), 16'h0001);
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b1, 8'h80);
    chk("gap_word1", 16'(col_b[7:0]), 16'h0080);
    chk("gap_word1_last", 16'(s_last_b), 16'h0001);
    for (int g = 0; g < 3; g++) begin
      do_cycle(1'b1, 1'b1, 8'h80);
      chk($sformatf("gap%0d_rdy", g), 16'(s_rdy_b), 16'h0000);
      chk($sformatf("gap%0d_xv", g),  16'(s_xv_b),  16'h0000);
      chk($sformatf("gap%0d_busy", g), 16'(s_busy_b), (g < 2) ? 16'h0001 : 16'h0000);
    end
    do_cycle(1'b1, 1'b1, 8'h80);
    chk("gap_second_rdy", 16'(s_rdy_b), 16'h0001);
    chk("gap_second_xv",  16'(s_xv_b),  16'h0001);
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, 8'h00);
    chk("gap_word2", 16'(col_b[7:0]), 16'h0001);

    // Reset mid-word on dut_a: FF cut after 3 bits, then 5A sent intact.
    idle_cycles(12);
    do_cycle(1'b1, 1'b1, 8'hFF);
    do_cycle(1'b1, 1'b0, 8'h00);
    do_cycle(1'b1, 1'b0, 8'h00);
    do_cycle(1'b0, 1'b1, 8'h5A);
    chk("rstmid_xv", 16'(s_xv_a), 16'h0000);
    chk("rstmid_busy", 16'(s_busy_a), 16'h0000);
    do_cycle(1'b0, 1'b1, 8'h5A);
    chk("rstmid_rdy", 16'(s_rdy_a), 16'h0000);
    col_a = 16'h0000;
    do_cycle(1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, 8'h00);
    chk("rstmid_5A", 16'(col_a[7:0]), 16'h005A);
    chk("rstmid_5A_last", 16'(s_last_a), 16'h0001);

    // Hold without handshake on dut_a, plus a reset glitch between edges.
    idle_cycles(12);
    col_a = 16'h0000;
    do_cycle(1'b1, 1'b1, 8'h3C);
    do_cycle(1'b1, 1'b1, 8'hC3);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    do_cycle(1'b1, 1'b1, 8'hC3);
    do_cycle(1'b1, 1'b1, 8'hC3);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b1, 8'h96);
    do_cycle(1'b1, 1'b1, 8'h96);
    chk("hold_accept_rdy", 16'(s_rdy_a), 16'h0001);
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, 8'h00);
    chk("hold_stream", col_a, 16'h3C96);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
               1'($urandom_range(0, 1)),
               8'($urandom));
    end
    idle_cycles(12);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
